// File: rtl/game_ctrl_fsm.sv
// Game sequencer: INIT/LOOP/UPDATE/OVER with cmd_done watchdog, game-over hold and mode cycling.
// Optional PAUSE state enabled by defining GAME_CTRL_PAUSE_EN.
module game_ctrl_fsm #(
  parameter int NUM_MODES   = 3,
  parameter int MODE_W      = $clog2(NUM_MODES),
  parameter int CMD_TIMEOUT = 1000,
  parameter int OVER_HOLD   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              game_over,
  input  logic              cmd_done,
  input  logic              diff,
  input  logic              mode_pb,
  output logic              init_cycle,
  output logic              enable_loop,
  output logic              en_update,
  output logic              sync_reset,
  output logic              paused,
  output logic [MODE_W-1:0] mode,
  output logic              cmd_timeout
);

  localparam int WD_W   = (CMD_TIMEOUT > 0) ? $clog2(CMD_TIMEOUT + 1) : 1;
  localparam int HOLD_W = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;
  localparam logic [WD_W-1:0]   WD_LAST   = (CMD_TIMEOUT > 0) ? WD_W'(CMD_TIMEOUT - 1) : '0;
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(OVER_HOLD);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam bit                WD_EN     = (CMD_TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_LOOP   = 3'd1,
    S_UPDATE = 3'd2,
    S_OVER   = 3'd3,
    S_PAUSE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              pb_q;
  logic              press;
  logic              wd_expire;
  logic              over_accept;
  logic [WD_W-1:0]   wd_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  // pb_q resets high so a button held through reset release is not a press
  assign press = mode_pb & ~pb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    wd_expire   = 1'b0;
    over_accept = 1'b0;
    case (state)
      S_INIT, S_UPDATE: begin
        if (cmd_done) begin
          state_nxt = S_LOOP;
        end else if (WD_EN && wd_cnt == WD_LAST) begin
          state_nxt = S_LOOP;
          wd_expire = 1'b1;
        end
      end
      S_LOOP: begin
        if (game_over)
          state_nxt = S_OVER;
`ifdef GAME_CTRL_PAUSE_EN
        else if (press)
          state_nxt = S_PAUSE;
`endif
        else if (diff)
          state_nxt = S_UPDATE;
      end
      S_OVER: begin
        if (press && hold_cnt == HOLD_MAX) begin
          state_nxt   = S_INIT;
          over_accept = 1'b1;
        end
      end
`ifdef GAME_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (press) state_nxt = S_LOOP;
      end
`endif
      default: state_nxt = S_INIT;
    endcase
  end

  // both counters restart on any state change so each visit begins at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb_q        <= 1'b1;
      wd_cnt      <= '0;
      hold_cnt    <= '0;
      mode        <= '0;
      cmd_timeout <= 1'b0;
    end else begin
      pb_q        <= mode_pb;
      cmd_timeout <= wd_expire;
      if (state_nxt != state) begin
        wd_cnt   <= '0;
        hold_cnt <= '0;
      end else begin
        if ((state == S_INIT || state == S_UPDATE) && !cmd_done)
          wd_cnt <= wd_cnt + WD_W'(1);
        if (state == S_OVER && hold_cnt != HOLD_MAX)
          hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      if (over_accept)
        mode <= (mode == MODE_LAST) ? '0 : mode + MODE_W'(1);
    end
  end

  assign init_cycle  = (state == S_INIT);
  assign enable_loop = (state == S_LOOP);
  assign en_update   = (state == S_UPDATE);
  assign sync_reset  = (state == S_OVER);
`ifdef GAME_CTRL_PAUSE_EN
  assign paused      = (state == S_PAUSE);
`else
  assign paused      = 1'b0;
`endif

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Bench for game_ctrl_fsm: directed scenarios then random traffic against a cycle-level model.
module tb_game_ctrl_fsm;
  localparam int NM   = 3;
  localparam int MW   = $clog2(NM);
  localparam int TO   = 8;
  localparam int HOLD = 4;
`ifdef GAME_CTRL_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int MI_INIT = 0, MI_LOOP = 1, MI_UPD = 2, MI_OVER = 3, MI_PAUSE = 4;

  logic          tb_clk = 1'b0;
  logic          rst, game_over, cmd_done, diff, mode_pb;
  logic          init_cycle, enable_loop, en_update, sync_reset, paused, cmd_timeout;
  logic [MW-1:0] mode;

  always #5 tb_clk = ~tb_clk;

  game_ctrl_fsm #(.NUM_MODES(NM), .CMD_TIMEOUT(TO), .OVER_HOLD(HOLD)) dut (
    .clk(tb_clk), .rst(rst), .game_over(game_over), .cmd_done(cmd_done),
    .diff(diff), .mode_pb(mode_pb), .init_cycle(init_cycle), .enable_loop(enable_loop),
    .en_update(en_update), .sync_reset(sync_reset), .paused(paused),
    .mode(mode), .cmd_timeout(cmd_timeout)
  );

  int total = 0;
  int bad   = 0;

  // model: current state, cycles already spent in it, mode, last button level, pulse
  int m_st, m_cyc, m_mode;
  bit m_pb, m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    logic [31:0] r;
    r = '0;
    r[5+MW:0] = {init_cycle, enable_loop, en_update, sync_reset, paused, cmd_timeout, mode};
    return r;
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] r;
    r = '0;
    r[5+MW:0] = {m_st == MI_INIT, m_st == MI_LOOP, m_st == MI_UPD, m_st == MI_OVER,
                 m_st == MI_PAUSE, m_to, MW'(m_mode)};
    return r;
  endfunction

  task automatic model_reset();
    m_st = MI_INIT; m_cyc = 0; m_mode = 0; m_pb = 1'b1; m_to = 1'b0;
  endtask

  task automatic model_clk(input bit go, input bit cd, input bit df, input bit pb);
    bit press;
    int nst;
    press = pb && !m_pb;
    m_pb  = pb;
    m_to  = 1'b0;
    nst   = m_st;
    case (m_st)
      MI_INIT, MI_UPD: begin
        if (cd) nst = MI_LOOP;
        else if (TO > 0 && m_cyc + 1 == TO) begin nst = MI_LOOP; m_to = 1'b1; end
      end
      MI_LOOP: begin
        if (go) nst = MI_OVER;
        else if (press && PAUSE_EN) nst = MI_PAUSE;
        else if (df) nst = MI_UPD;
      end
      MI_OVER: begin
        if (press && m_cyc + 1 > HOLD) begin
          nst = MI_INIT;
          m_mode = (m_mode + 1) % NM;
        end
      end
      MI_PAUSE: if (press) nst = MI_LOOP;
      default: ;
    endcase
    m_cyc = (nst != m_st) ? 0 : m_cyc + 1;
    m_st  = nst;
  endtask

  task automatic step(input string tag, input bit go, input bit cd, input bit df, input bit pb);
    game_over = go; cmd_done = cd; diff = df; mode_pb = pb;
    @(posedge tb_clk);
    model_clk(go, cd, df, pb);
    #1;
    chk(tag, dut_vec(), exp_vec());
  endtask

  // from LOOP: game over, wait the hold, press at the earliest accepted OVER cycle
  task automatic finish_round(input string tag);
    step({tag, "_go"}, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (HOLD) step({tag, "_hold"}, 1'b0, 1'b0, 1'b0, 1'b0);
    step({tag, "_exit"}, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst", dut_vec(), exp_vec());
    @(posedge tb_clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; game_over = 1'b0; cmd_done = 1'b0; diff = 1'b0; mode_pb = 1'b1;
    model_reset();
    repeat (2) @(posedge tb_clk);
    #1;
    chk("rst_outs", dut_vec(), exp_vec());
    chk("rst_init", init_cycle, 1);
    chk("rst_mode", mode, 0);
    rst = 1'b0;

    repeat (3) step("pb_held", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pb_held_init", init_cycle, 1);

    // full cycle
    step("fc_init", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("fc_loop", enable_loop, 1);
    step("fc_diff", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("fc_update", en_update, 1);
    step("fc_done", 1'b0, 1'b1, 1'b0, 1'b1);
    step("fc_go", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fc_over", sync_reset, 1);
    step("fc_o1", 1'b1, 1'b0, 1'b0, 1'b0);
    step("fc_o2", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("fc_early_press", sync_reset, 1);
    step("fc_o3", 1'b1, 1'b0, 1'b0, 1'b0);
    step("fc_o4", 1'b1, 1'b0, 1'b0, 1'b0);
    step("fc_o5", 1'b1, 1'b0, 1'b0, 1'b0);
    step("fc_o6", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("fc_exit_init", init_cycle, 1);
    chk("fc_mode1", mode, 1);

    // mode wrap
    step("mw_init", 1'b0, 1'b1, 1'b0, 1'b0);
    finish_round("mw2");
    chk("mw_mode2", mode, 2);
    step("mw_init", 1'b0, 1'b1, 1'b0, 1'b0);
    finish_round("mw0");
    chk("mw_mode0", mode, 0);

    // watchdog expiry from INIT
    n = 0;
    while (!enable_loop && n < 20) begin
      step("wd_wait", 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("wd_cycles", n, TO);
    chk("wd_pulse", cmd_timeout, 1);
    step("wd_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_pulse_end", cmd_timeout, 0);

    // cmd_done in the last watchdog cycle wins, no pulse
    finish_round("wdp");
    repeat (TO - 1) step("wdp_wait", 1'b0, 1'b0, 1'b0, 0);
    step("wdp_done", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("wdp_loop", enable_loop, 1);
    chk("wdp_no_pulse", cmd_timeout, 0);

    // priority: game_over beats press and diff
    step("pr_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step("pr_all", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("pr_over", sync_reset, 1);
    repeat (HOLD) step("pr_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    step("pr_exit", 1'b0, 1'b0, 1'b0, 1'b1);

    // pause
    step("pa_init", 1'b0, 1'b1, 1'b0, 1'b0);
    step("pa_press", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pa_paused", paused, PAUSE_EN);
    chk("pa_loop", enable_loop, !PAUSE_EN);
    step("pa_diff", 1'b0, 1'b1, 1'b1, 1'b1);
    step("pa_rel", 1'b0, 1'b0, 1'b0, 1'b0);
    step("pa_press2", 1'b0, 1'b0, 1'b0, 1'b1);

    // random traffic with occasional asynchronous reset
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else step("rand", $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 35);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/game_ctrl_fsm.md
# game_ctrl_fsm

Parametrised top-level game sequencer: a successor to the four-state INIT/LOOP/UPDATE/OVER controller. It sits between the game logic (`game_over`, `diff`), the display command engine (`cmd_done`) and the mode push-button. It adds the following over the fixed controller:
- a cmd_done watchdog;
- a minimum game-over hold time;
- a difficulty/mode register cycled by the button;
- an optional pause state.

## Interface
Parameters:
- `NUM_MODES`, 3: number of selectable modes, ≥2.
- `MODE_W`, `$clog2(NUM_MODES)`: mode output width (derived; do not override).
- `CMD_TIMEOUT`, 1000: max cycles waiting for `cmd_done` in INIT/UPDATE. 0 disables the watchdog.
- `OVER_HOLD`, 4: cycles OVER must last before a button press is accepted. 0 means immediate.

Ports:
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: reset; asynchronous, active-high.
- `game_over` in 1: level; game ended.
- `cmd_done` in 1: level; display command engine finished.
- `diff` in 1: level; game state changed, redraw needed.
- `mode_pb` in 1: synchronised, debounced push-button level.
- `init_cycle` out 1: high in INIT.
- `enable_loop` out 1: high in LOOP.
- `en_update` out 1: high in UPDATE.
- `sync_reset` out 1: high in OVER.
- `paused` out 1: high in PAUSE.
- `mode` out MODE_W: current mode, 0..NUM_MODES-1.
- `cmd_timeout` out 1: one-cycle pulse when the watchdog forces an exit.

## Operation
- **Button press detection:** press = `mode_pb & ~pb_q`, where `pb_q` is the registered `mode_pb`.
- **State outputs:** `init_cycle`, `enable_loop`, `en_update`, `sync_reset` and `paused` are a one-hot decode of the state register (Moore). At most one of them is high in any cycle.
- **INIT:**
  - `cmd_done` → LOOP.
  - Watchdog expiry → LOOP, with `cmd_timeout` pulsed.
- **LOOP:** priority `game_over` > press > `diff`.
  - `game_over` → OVER.
  - press → PAUSE (macro on only).
  - `diff` → UPDATE.
  - Otherwise stay.
- **UPDATE:**
  - `cmd_done` → LOOP.
  - Watchdog expiry → LOOP, with `cmd_timeout` pulsed.
  - `game_over` is ignored until LOOP.
- **OVER:**
  - `hold_cnt` increments each cycle and saturates at OVER_HOLD.
  - A press with `hold_cnt == OVER_HOLD` → INIT, and `mode <= (mode == NUM_MODES-1) ? 0 : mode+1`.
  - Presses before the hold has elapsed are discarded, not queued.
- **PAUSE:**
  - Press → LOOP.
  - `game_over`, `diff` and `cmd_done` are ignored.
- **Watchdog counter (`wd_cnt`):**
  - Width `$clog2(CMD_TIMEOUT+1)`.
  - Cleared on every state change.
  - Increments each cycle in INIT/UPDATE while `cmd_done` is low.
  - Expiry is `wd_cnt == CMD_TIMEOUT-1` with `cmd_done` low.
  - `cmd_done` has priority over expiry in the same cycle; no pulse is generated then.
- **Mode register:** changes only on an accepted OVER exit. It is never cleared by `game_over` or `sync_reset`.

## Timing
- Inputs are sampled at posedge N. The new state and its decoded outputs are visible after posedge N, i.e. one cycle of latency.
- A press is recognised in the cycle `mode_pb` first reads high. Holding the button generates no further presses.
- `cmd_timeout` is registered and is high exactly during the first LOOP cycle after a forced exit.
- With OVER_HOLD = H, the earliest accepted press is sampled in the (H+1)-th OVER cycle.
- **Reset values:**
  - state INIT, so `init_cycle`=1.
  - `enable_loop`, `en_update`, `sync_reset`, `paused`, `cmd_timeout` = 0.
  - `mode`=0, `wd_cnt`=0, `hold_cnt`=0.
  - `pb_q`=1, so a button held through reset release is not a press.
- **Reset mid-operation:** `rst` asserted in any state forces the reset values immediately, independent of `clk`. `mode` is lost.

## Configuration
- `GAME_CTRL_PAUSE_EN` defined:
  - PAUSE state is present.
  - A press in LOOP enters PAUSE; a press in PAUSE returns to LOOP.
- Not defined:
  - No PAUSE state.
  - Presses in LOOP are ignored.
  - `paused` is tied to 0.
  - All other behaviour is identical.

## Test plan
Defaults unless stated.

- **Reset:** assert `rst` with `mode_pb`=1, then release.
  - `init_cycle`=1, all other outputs 0, `mode`=0.
  - No transition while `mode_pb` stays high.
- **Full cycle:**
  - `cmd_done`=1 → LOOP.
  - `diff`=1 → UPDATE.
  - `cmd_done` → LOOP.
  - `game_over`=1 → OVER with `sync_reset`=1.
  - Press at OVER cycle 2 → ignored.
  - Press at cycle 6 → INIT, `mode`=1.
- **Mode wrap:** three accepted OVER exits → `mode` goes 1, 2, 0.
- **Watchdog:** CMD_TIMEOUT=8; hold `cmd_done`=0 in INIT.
  - LOOP entered after exactly 8 INIT cycles.
  - `cmd_timeout`=1 for one cycle.
  - `cmd_done` rising in the 8th cycle → no pulse.
- **Priority:** in LOOP, assert `game_over`, `diff` and a press in the same cycle → OVER.
- **Pause** (macro on): press in LOOP → `paused`=1; `diff` ignored; second press → LOOP. With the macro off, the same press leaves the state in LOOP.
